// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and a
// block-wide instruction memory; a miss stalls the CPU while one line is filled.
module instr_cache #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_BITS   = 10,
    localparam int IDX_W      = $clog2(NUM_BLOCKS),
    localparam int OFF_W      = $clog2(BLOCK_WORDS),
    localparam int TAG_W      = ADDR_BITS - IDX_W - OFF_W - 2,
    localparam int BLK_ADDR_W = ADDR_BITS - OFF_W - 2,
    localparam int LINE_W     = 32 * BLOCK_WORDS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  mem_read,
    output logic [BLK_ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0]     mem_readdata,
    input  logic                  mem_busywait,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Address split: | tag | index | word | byte |
    logic [TAG_W-1:0]      pc_tag;
    logic [IDX_W-1:0]      pc_index;
    logic [OFF_W-1:0]      pc_word;
    logic [BLK_ADDR_W-1:0] pc_block;
    logic                  unused_pc_bits;

    assign pc_tag         = PC[ADDR_BITS-1 -: TAG_W];
    assign pc_index       = PC[OFF_W+2 +: IDX_W];
    assign pc_word        = PC[2 +: OFF_W];
    assign pc_block       = PC[ADDR_BITS-1 -: BLK_ADDR_W];
    assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

    logic                  hit;
    logic                  fill_en;
    logic                  busy_c;
    logic [LINE_W-1:0]     line_sel;
    logic [31:0]           line_words [BLOCK_WORDS];

    assign hit = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    always_comb begin
        line_sel = data_q[pc_index];
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            line_words[w] = line_sel[w*32 +: 32];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mem_read/mem_address come straight from the state, so a reset mid-fill
    // drops the request on the same edge that returns the FSM to IDLE.
    always_comb begin
        state_next  = state;
        busy_c      = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        fill_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    busy_c     = 1'b1;
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                busy_c      = 1'b1;
                mem_read    = 1'b1;
                mem_address = pc_block;
                if (!mem_busywait) begin
                    fill_en    = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                busy_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[pc_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through valid_q.
    always_ff @(posedge CLK) begin
        if (fill_en && !RESET) begin
            tag_q[pc_index]  <= pc_tag;
            data_q[pc_index] <= mem_readdata;
        end
    end

    assign BUSYWAIT    = RESET ? 1'b0 : busy_c;
    assign INSTRUCTION = RESET ? 32'd0 : line_words[pc_word];
    assign dbg_state   = state;

    a_read_implies_stall : assert property (
        @(posedge CLK) disable iff (RESET) mem_read |-> BUSYWAIT);

    a_update_to_idle : assert property (
        @(posedge CLK) disable iff (RESET) (state == UPDATE) |=> (state == IDLE));

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: a latency-programmable block memory model
// answers fill requests and each task checks one behaviour of the cache.
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 5;
    int mem_cnt  = 0;
    int req_count = 0;
    logic [5:0] last_req_addr = '0;
    logic       prev_read = 1'b0;
    logic [31:0] exp_q[$];

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .dbg_state    (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Memory image: every word encodes its block address and word offset.
    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
        return {8'hCA, 2'b00, blk, 8'h5E, 6'b000000, w};
    endfunction

    // Memory stays busy for mem_lat cycles of a request, then presents data.
    assign mem_busywait = mem_read && (mem_cnt < mem_lat);
    assign mem_readdata = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                           mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};

    always @(posedge CLK) begin
        mem_cnt <= mem_read ? mem_cnt + 1 : 0;
    end

    always @(negedge CLK) begin
        if (mem_read && !prev_read) begin
            req_count++;
            last_req_addr = mem_address;
        end
        prev_read = mem_read;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Counts stalled cycles until BUSYWAIT is low at a falling edge.
    task automatic wait_ready(output int busy);
        busy = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (BUSYWAIT === 1'b0) return;
            busy++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_ready_timeout pc=%h busy=%0d", PC, busy);
    endtask

    task automatic fetch(input logic [31:0] pc, output int busy);
        @(posedge CLK);
        #1;
        PC = pc;
        wait_ready(busy);
    endtask

    task automatic test_reset;
        int busy;
        RESET = 1'b1;
        PC    = 32'h000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rst_busywait got=%b exp=0", BUSYWAIT); end
        n_checks++; if (INSTRUCTION !== 32'd0) begin n_fail++; $display("FAIL rst_instr got=%h exp=0", INSTRUCTION); end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
        n_checks++; if (mem_address !== 6'd0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_address); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++; if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL t1_cycle0_busy got=%b exp=1", BUSYWAIT); end
        @(negedge CLK);
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL t1_mem_read got=%b exp=1", mem_read); end
        n_checks++; if (mem_address !== 6'd0) begin n_fail++; $display("FAIL t1_mem_addr got=%h exp=0", mem_address); end
        wait_ready(busy);
        // 2 already-counted cycles, then the rest of MEM_READ and UPDATE: lat + 3 total
        n_checks++; if (busy + 2 !== mem_lat + 3) begin n_fail++; $display("FAIL t1_penalty got=%0d exp=%0d", busy + 2, mem_lat + 3); end
        n_checks++; if (INSTRUCTION !== mem_word(6'd0, 2'd0)) begin n_fail++; $display("FAIL t1_instr got=%h exp=%h", INSTRUCTION, mem_word(6'd0, 2'd0)); end
        n_checks++; if (req_count !== 1) begin n_fail++; $display("FAIL t1_requests got=%0d exp=1", req_count); end
    endtask

    task automatic test_hits;
        int busy;
        int r0;
        r0 = req_count;
        for (int w = 1; w < 4; w++) begin
            fetch(32'(w * 4), busy);
            n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL hit_busy w=%0d got=%0d exp=0", w, busy); end
            n_checks++; if (INSTRUCTION !== mem_word(6'd0, 2'(w))) begin n_fail++; $display("FAIL hit_instr w=%0d got=%h exp=%h", w, INSTRUCTION, mem_word(6'd0, 2'(w))); end
            n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL hit_mem_read w=%0d got=%b exp=0", w, mem_read); end
        end
        n_checks++; if (req_count !== r0) begin n_fail++; $display("FAIL hit_requests got=%0d exp=%0d", req_count, r0); end
    endtask

    task automatic test_conflict;
        int busy;
        int r0;
        r0 = req_count;
        fetch(32'h080, busy);
        n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL conf_miss_busy got=%0d exp=%0d", busy, mem_lat + 3); end
        n_checks++; if (last_req_addr !== 6'h08) begin n_fail++; $display("FAIL conf_addr got=%h exp=08", last_req_addr); end
        n_checks++; if (INSTRUCTION !== mem_word(6'h08, 2'd0)) begin n_fail++; $display("FAIL conf_instr got=%h exp=%h", INSTRUCTION, mem_word(6'h08, 2'd0)); end
        fetch(32'h000, busy);
        n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL conf_remiss_busy got=%0d exp=%0d", busy, mem_lat + 3); end
        n_checks++; if (last_req_addr !== 6'h00) begin n_fail++; $display("FAIL conf_readdr got=%h exp=00", last_req_addr); end
        n_checks++; if (INSTRUCTION !== mem_word(6'h00, 2'd0)) begin n_fail++; $display("FAIL conf_reinstr got=%h exp=%h", INSTRUCTION, mem_word(6'h00, 2'd0)); end
        fetch(32'h084, busy);
        n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL conf_evicted_busy got=%0d exp=%0d", busy, mem_lat + 3); end
        n_checks++; if (INSTRUCTION !== mem_word(6'h08, 2'd1)) begin n_fail++; $display("FAIL conf_evicted_instr got=%h exp=%h", INSTRUCTION, mem_word(6'h08, 2'd1)); end
        n_checks++; if (req_count - r0 !== 3) begin n_fail++; $display("FAIL conf_requests got=%0d exp=3", req_count - r0); end
    endtask

    task automatic test_reset_mid_fill;
        int busy;
        mem_lat = 20;
        @(posedge CLK);
        #1;
        PC = 32'h010;
        repeat (3) @(negedge CLK);
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL mid_mem_read got=%b exp=1", mem_read); end
        n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL mid_state got=%0d exp=1", dbg_state); end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", BUSYWAIT); end
        n_checks++; if (INSTRUCTION !== 32'd0) begin n_fail++; $display("FAIL mid_rst_instr got=%h exp=0", INSTRUCTION); end
        @(posedge CLK);
        #1;
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL mid_drop_read got=%b exp=0", mem_read); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL mid_drop_state got=%0d exp=0", dbg_state); end
        RESET   = 1'b0;
        mem_lat = 5;
        @(negedge CLK);
        n_checks++; if (BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL mid_refetch_miss got=%b exp=1", BUSYWAIT); end
        wait_ready(busy);
        n_checks++; if (busy + 1 !== mem_lat + 3) begin n_fail++; $display("FAIL mid_refetch_busy got=%0d exp=%0d", busy + 1, mem_lat + 3); end
        n_checks++; if (INSTRUCTION !== mem_word(6'h01, 2'd0)) begin n_fail++; $display("FAIL mid_refetch_instr got=%h exp=%h", INSTRUCTION, mem_word(6'h01, 2'd0)); end
        // Reset cleared every line, including the one filled earlier at index 0
        fetch(32'h084, busy);
        n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL mid_invalidated got=%0d exp=%0d", busy, mem_lat + 3); end
    endtask

    task automatic test_long_stall;
        int busy;
        int both;
        int r0;
        logic done;
        mem_lat = 40;
        r0   = req_count;
        busy = 0;
        both = 0;
        done = 1'b0;
        @(posedge CLK);
        #1;
        PC = 32'h3F4;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (BUSYWAIT === 1'b0) begin
                done = 1'b1;
            end else begin
                busy++;
                if (mem_read === 1'b1) both++;
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_timeout got=%b exp=1", done); end
        n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL stall_busy got=%0d exp=%0d", busy, mem_lat + 3); end
        n_checks++; if (both !== mem_lat + 1) begin n_fail++; $display("FAIL stall_read_window got=%0d exp=%0d", both, mem_lat + 1); end
        n_checks++; if (req_count - r0 !== 1) begin n_fail++; $display("FAIL stall_requests got=%0d exp=1", req_count - r0); end
        n_checks++; if (INSTRUCTION !== mem_word(6'h3F, 2'd1)) begin n_fail++; $display("FAIL stall_instr got=%h exp=%h", INSTRUCTION, mem_word(6'h3F, 2'd1)); end
        mem_lat = 5;
    endtask

    task automatic test_fill_all;
        int busy;
        logic [31:0] exp;
        mem_lat = 3;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        PC    = 32'h000;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        wait_ready(busy);
        n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL fill_busy i=0 got=%0d exp=%0d", busy, mem_lat + 3); end
        for (int i = 1; i < 8; i++) begin
            fetch(32'(i * 16), busy);
            n_checks++; if (busy !== mem_lat + 3) begin n_fail++; $display("FAIL fill_busy i=%0d got=%0d exp=%0d", i, busy, mem_lat + 3); end
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mem_word(6'(i), 2'(i % 4)));
        end
        for (int i = 0; i < 8; i++) begin
            fetch(32'(i * 16 + (i % 4) * 4), busy);
            exp = exp_q.pop_front();
            n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL revisit_busy i=%0d got=%0d exp=0", i, busy); end
            n_checks++; if (INSTRUCTION !== exp) begin n_fail++; $display("FAIL revisit_instr i=%0d got=%h exp=%h", i, INSTRUCTION, exp); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        PC    = 32'h000;
        test_reset();
        test_hits();
        test_conflict();
        test_reset_mid_fill();
        test_long_stall();
        test_fill_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
